// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// immediate-format selects and ALU control codes.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StJal,
      StAluWb,
      StBeq
   } statetype;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/riscv_mc_controller_if.sv
// Controller <-> datapath signal bundle: instruction fields and flags in,
// mux selects and write enables out.
interface riscv_mc_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic [1:0] immsrc;
   logic [1:0] alusrca;
   logic [1:0] alusrcb;
   logic [1:0] resultsrc;
   logic [2:0] alucontrol;
   logic       adrsrc;
   logic       irwrite;
   logic       pcwrite;
   logic       regwrite;
   logic       memwrite;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  op, funct3, funct7b5, zero,
      output immsrc, alusrca, alusrcb, resultsrc, alucontrol, adrsrc,
             irwrite, pcwrite, regwrite, memwrite, instr_done, illegal
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  immsrc, alusrca, alusrcb, resultsrc, alucontrol, adrsrc,
             irwrite, pcwrite, regwrite, memwrite, instr_done, illegal
   );
endinterface

// File: rtl/riscv_aludec.sv
// ALU decoder: maps the FSM's aluop class plus funct fields to an ALU control code.
module riscv_aludec
   import riscv_mc_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type (op5=1) can encode sub; addi with imm[10] set stays add.
               3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control unit: Moore main FSM, inline immsrc decode, ALU decoder.
// Define RISCV_MC_CTRL_BNE_EN to let the B-type path also take bne (funct3=001).
module riscv_mc_controller
   import riscv_mc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   riscv_mc_controller_if.master ctrl
);

   statetype   state_q, state_d;
   logic [1:0] alusrca, alusrcb, resultsrc, aluop, immsrc;
   logic       adrsrc, irwrite, pcupdate, branch, regwrite, memwrite;
   logic       instr_done, illegal, taken;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= StFetch;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = StFetch;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      resultsrc  = 2'b00;
      aluop      = ALUOP_ADD;
      adrsrc     = 1'b0;
      irwrite    = 1'b0;
      pcupdate   = 1'b0;
      branch     = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         StFetch: begin
            irwrite   = 1'b1;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            pcupdate  = 1'b1;
            state_d   = StDecode;
         end
         StDecode: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (ctrl.op)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_R:         state_d = StExecR;
               OP_I:         state_d = StExecI;
               OP_BEQ:       state_d = StBeq;
               OP_JAL:       state_d = StJal;
               default: begin
                  state_d = StFetch;
                  illegal = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            state_d = ctrl.op[5] ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            adrsrc  = 1'b1;
            state_d = StMemWb;
         end
         StMemWb: begin
            resultsrc  = 2'b01;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         StMemWrite: begin
            adrsrc     = 1'b1;
            memwrite   = 1'b1;
            instr_done = 1'b1;
         end
         StExecR: begin
            alusrca = 2'b10;
            aluop   = ALUOP_FUNCT;
            state_d = StAluWb;
         end
         StExecI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluop   = ALUOP_FUNCT;
            state_d = StAluWb;
         end
         StJal: begin
            alusrca  = 2'b01;
            alusrcb  = 2'b10;
            pcupdate = 1'b1;
            state_d  = StAluWb;
         end
         StAluWb: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         StBeq: begin
            alusrca    = 2'b10;
            aluop      = ALUOP_SUB;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         default: state_d = StFetch;
      endcase

      // Reset held low aborts the current instruction: nothing may commit.
      if (!reset) begin
         irwrite    = 1'b0;
         pcupdate   = 1'b0;
         branch     = 1'b0;
         regwrite   = 1'b0;
         memwrite   = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

`ifdef RISCV_MC_CTRL_BNE_EN
   assign taken = (ctrl.funct3 == 3'b001) ? ~ctrl.zero : ctrl.zero;
`else
   assign taken = ctrl.zero;
`endif

   always_comb begin
      case (ctrl.op)
         OP_LW, OP_I: immsrc = IMM_I;
         OP_SW:       immsrc = IMM_S;
         OP_BEQ:      immsrc = IMM_B;
         OP_JAL:      immsrc = IMM_J;
         default:     immsrc = IMM_I;
      endcase
   end

   riscv_aludec u_aludec (
      .aluop      (aluop),
      .funct3     (ctrl.funct3),
      .op5        (ctrl.op[5]),
      .funct7b5   (ctrl.funct7b5),
      .alucontrol (ctrl.alucontrol)
   );

   assign ctrl.immsrc     = immsrc;
   assign ctrl.alusrca    = alusrca;
   assign ctrl.alusrcb    = alusrcb;
   assign ctrl.resultsrc  = resultsrc;
   assign ctrl.adrsrc     = adrsrc;
   assign ctrl.irwrite    = irwrite;
   assign ctrl.pcwrite    = pcupdate | (branch & taken);
   assign ctrl.regwrite   = regwrite;
   assign ctrl.memwrite   = memwrite;
   assign ctrl.instr_done = instr_done;
   assign ctrl.illegal    = illegal;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller: per-cycle output vectors for each instruction class.
module tb_riscv_mc_controller;

   // {immsrc, alusrca, alusrcb, resultsrc, alucontrol, adrsrc, irwrite, pcwrite,
   //  regwrite, memwrite, instr_done, illegal}
   typedef logic [17:0] vec_t;
   typedef vec_t seq_t [5];

   localparam logic [6:0] F_NONE  = 7'b0000000;
   localparam logic [6:0] F_FETCH = 7'b0110000;
   localparam logic [6:0] F_ADR   = 7'b1000000;
   localparam logic [6:0] F_WB    = 7'b0001010;
   localparam logic [6:0] F_SW    = 7'b1000110;
   localparam logic [6:0] F_JAL   = 7'b0010000;
   localparam logic [6:0] F_BT    = 7'b0010010;
   localparam logic [6:0] F_BN    = 7'b0000010;
   localparam logic [6:0] F_ILL   = 7'b0000001;
`ifdef RISCV_MC_CTRL_BNE_EN
   localparam logic [6:0] F_BNE_Z1 = F_BN;
   localparam logic [6:0] F_BNE_Z0 = F_BT;
`else
   localparam logic [6:0] F_BNE_Z1 = F_BT;
   localparam logic [6:0] F_BNE_Z0 = F_BN;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   riscv_mc_controller_if bus ();

   riscv_mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus.master)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(logic [1:0] imm, logic [1:0] a, logic [1:0] b,
                              logic [1:0] res, logic [2:0] alu, logic [6:0] fl);
      return {imm, a, b, res, alu, fl};
   endfunction

   function automatic vec_t fetch_v(logic [1:0] imm);
      return v(imm, 2'b00, 2'b10, 2'b10, 3'b000, F_FETCH);
   endfunction

   function automatic vec_t decode_v(logic [1:0] imm);
      return v(imm, 2'b01, 2'b01, 2'b00, 3'b000, F_NONE);
   endfunction

   function automatic vec_t observe();
      return {bus.immsrc, bus.alusrca, bus.alusrcb, bus.resultsrc, bus.alucontrol,
              bus.adrsrc, bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite,
              bus.instr_done, bus.illegal};
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   task automatic drive(logic [31:0] instr, logic z);
      bus.op       = instr[6:0];
      bus.funct3   = instr[14:12];
      bus.funct7b5 = instr[30];
      bus.zero     = z;
   endtask

   // Called just after a clock edge that entered FETCH; leaves just after the
   // edge following the n-th checked cycle.
   task automatic run_instr(string name, int n, seq_t exp);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check($sformatf("%s.c%0d", name, i + 1), 32'(observe()), 32'(exp[i]));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      drive(32'h0000_0000, 1'b0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_held", 32'(observe()), 32'(v(2'b00, 2'b00, 2'b10, 2'b10, 3'b000, F_NONE)));
      @(posedge clk);
      #1;
      reset = 1'b1;

      drive(32'hffc3a303, 1'b0);
      run_instr("lw", 5, '{fetch_v(2'b00), decode_v(2'b00),
                           v(2'b00, 2'b10, 2'b01, 2'b00, 3'b000, F_NONE),
                           v(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_ADR),
                           v(2'b00, 2'b00, 2'b00, 2'b01, 3'b000, F_WB)});

      drive(32'h01d3a423, 1'b0);
      run_instr("sw", 4, '{fetch_v(2'b01), decode_v(2'b01),
                           v(2'b01, 2'b10, 2'b01, 2'b00, 3'b000, F_NONE),
                           v(2'b01, 2'b00, 2'b00, 2'b00, 3'b000, F_SW), '0});

      drive(32'h000e8e63, 1'b1);
      run_instr("beq_z1", 3, '{fetch_v(2'b10), decode_v(2'b10),
                               v(2'b10, 2'b10, 2'b00, 2'b00, 3'b001, F_BT), '0, '0});

      drive(32'h000e8e63, 1'b0);
      run_instr("beq_z0", 3, '{fetch_v(2'b10), decode_v(2'b10),
                               v(2'b10, 2'b10, 2'b00, 2'b00, 3'b001, F_BN), '0, '0});

      drive(32'h000e9e63, 1'b1);
      run_instr("bne_z1", 3, '{fetch_v(2'b10), decode_v(2'b10),
                               v(2'b10, 2'b10, 2'b00, 2'b00, 3'b001, F_BNE_Z1), '0, '0});

      drive(32'h000e9e63, 1'b0);
      run_instr("bne_z0", 3, '{fetch_v(2'b10), decode_v(2'b10),
                               v(2'b10, 2'b10, 2'b00, 2'b00, 3'b001, F_BNE_Z0), '0, '0});

      drive(32'h008000ef, 1'b0);
      run_instr("jal", 4, '{fetch_v(2'b11), decode_v(2'b11),
                            v(2'b11, 2'b01, 2'b10, 2'b00, 3'b000, F_JAL),
                            v(2'b11, 2'b00, 2'b00, 2'b00, 3'b000, F_WB), '0});

      drive(32'h40000033, 1'b1);
      run_instr("sub", 4, '{fetch_v(2'b00), decode_v(2'b00),
                            v(2'b00, 2'b10, 2'b00, 2'b00, 3'b001, F_NONE),
                            v(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_WB), '0});

      drive(32'h00007033, 1'b0);
      run_instr("and", 4, '{fetch_v(2'b00), decode_v(2'b00),
                            v(2'b00, 2'b10, 2'b00, 2'b00, 3'b010, F_NONE),
                            v(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_WB), '0});

      drive(32'h00002033, 1'b0);
      run_instr("slt", 4, '{fetch_v(2'b00), decode_v(2'b00),
                            v(2'b00, 2'b10, 2'b00, 2'b00, 3'b101, F_NONE),
                            v(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_WB), '0});

      drive(32'h40000013, 1'b0);
      run_instr("addi_b30", 4, '{fetch_v(2'b00), decode_v(2'b00),
                                 v(2'b00, 2'b10, 2'b01, 2'b00, 3'b000, F_NONE),
                                 v(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_WB), '0});

      drive(32'h00006013, 1'b0);
      run_instr("ori", 4, '{fetch_v(2'b00), decode_v(2'b00),
                            v(2'b00, 2'b10, 2'b01, 2'b00, 3'b011, F_NONE),
                            v(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_WB), '0});

      drive(32'h0000_0000, 1'b0);
      run_instr("illegal", 2, '{fetch_v(2'b00),
                                v(2'b00, 2'b01, 2'b01, 2'b00, 3'b000, F_ILL), '0, '0, '0});

      // Abort an lw in MEMREAD: must restart at FETCH rather than reach MEMWB.
      drive(32'hffc3a303, 1'b0);
      run_instr("lw_abort", 3, '{fetch_v(2'b00), decode_v(2'b00),
                                 v(2'b00, 2'b10, 2'b01, 2'b00, 3'b000, F_NONE), '0, '0});
      reset = 1'b0;
      @(negedge clk);
      check("lw_abort.memread", 32'(observe()),
            32'(v(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_ADR)));
      @(posedge clk);
      #1;
      reset = 1'b1;
      run_instr("lw_restart", 2, '{fetch_v(2'b00), decode_v(2'b00), '0, '0, '0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
